// File: rtl/lcd_nibble_writer.sv
// HD44780 4-bit bus writer: sends a byte as two nibbles (or one nibble during init)
// with setup, enable-pulse, hold and post-transfer command-wait phases.
module lcd_nibble_writer #(
  parameter int unsigned SETUP_CYCLES = 2,
  parameter int unsigned EN_CYCLES    = 6,
  parameter int unsigned DELAY_BIT    = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       i_valid,
  output logic       i_ready,
  input  logic [7:0] i_data,
  input  logic       i_rs,
  input  logic       i_nibble_only,
  output logic [3:0] lcd_data,
  output logic       lcd_en,
  output logic       lcd_rs,
  output logic       o_done
);

  localparam int unsigned WaitCycles = 1 << DELAY_BIT;
  localparam int unsigned PhaseMax   = (SETUP_CYCLES > EN_CYCLES) ? SETUP_CYCLES : EN_CYCLES;
  localparam int unsigned CntMax     = (PhaseMax > WaitCycles) ? PhaseMax : WaitCycles;
  localparam int unsigned CntW       = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] SetupLd = CntW'(SETUP_CYCLES - 1);
  localparam logic [CntW-1:0] EnLd    = CntW'(EN_CYCLES - 1);
  localparam logic [CntW-1:0] WaitLd  = CntW'(WaitCycles - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StWait
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [3:0]      low_q, low_d;
  logic            second_q, second_d;
  logic [3:0]      data_q, data_d;
  logic            rs_q, rs_d;
  logic            en_q, en_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      low_q    <= '0;
      second_q <= 1'b0;
      data_q   <= '0;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      low_q    <= low_d;
      second_q <= second_d;
      data_q   <= data_d;
      rs_q     <= rs_d;
      en_q     <= en_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    low_d    = low_q;
    second_d = second_q;
    data_d   = data_q;
    rs_d     = rs_q;

    unique case (state_q)
      StIdle: begin
        if (i_valid) begin
          state_d  = StSetup;
          cnt_d    = SetupLd;
          data_d   = i_data[7:4];
          low_d    = i_data[3:0];
          rs_d     = i_rs;
          second_d = ~i_nibble_only;
        end
      end
      StSetup: begin
        if (cnt_q == '0) begin
          state_d = StPulse;
          cnt_d   = EnLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StPulse: begin
        if (cnt_q == '0) begin
          state_d = StHold;
          cnt_d   = EnLd;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHold: begin
        if (cnt_q == '0) begin
          if (second_q) begin
            // Second pass puts the low nibble on the bus for its own setup window.
            state_d  = StSetup;
            cnt_d    = SetupLd;
            data_d   = low_q;
            second_d = 1'b0;
          end else begin
            state_d = StWait;
            cnt_d   = WaitLd;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Registered strobe keeps EN free of decode glitches.
    en_d = (state_d == StPulse);
  end

  assign i_ready  = (state_q == StIdle);
  assign o_done   = (state_q == StWait) && (cnt_q == '0);
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_en   = en_q;

endmodule
